// File: rtl/tree_reduce_pkg.sv
// rtl/tree_reduce_pkg.sv - shared types, width helpers and beat-count decode for tree_reduce_sequencer
package tree_reduce_pkg;

  // DRAIN is only reachable when TREE_REDUCE_PIPE_EN is defined
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int tree_width(input int inputs, input int p);
    return p + $clog2(inputs);
  endfunction

  function automatic int sum_width(input int inputs, input int p, input int max_beats);
    return p + $clog2(inputs) + $clog2(max_beats);
  endfunction

  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // zero beats means one; anything above the maximum is clamped
  function automatic int decode_beats(input int cfg, input int max_beats);
    if (cfg == 0) begin
      return 1;
    end
    if (cfg > max_beats) begin
      return max_beats;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/binary_tree_adder_unsigned.sv
// rtl/binary_tree_adder_unsigned.sv - combinational unsigned pairwise adder tree
module binary_tree_adder_unsigned #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P = 8,
  localparam int OUT_W = P + $clog2(INPUTS_AMOUNT)
) (
  input  logic [P-1:0]     in_data [INPUTS_AMOUNT],
  output logic [OUT_W-1:0] sum
);

  logic [OUT_W-1:0] node [INPUTS_AMOUNT];

  // halve the operand set each level, adding neighbours, until one value remains
  always_comb begin
    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
      node[i] = OUT_W'(in_data[i]);
    end
    for (int w = INPUTS_AMOUNT / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    sum = node[0];
  end

endmodule

// File: rtl/tree_reduce_sequencer.sv
// rtl/tree_reduce_sequencer.sv - streams beats through an adder tree and accumulates one result per reduction (option: TREE_REDUCE_PIPE_EN)
module tree_reduce_sequencer
  import tree_reduce_pkg::*;
#(
  parameter int INPUTS = 8,
  parameter int P = 8,
  parameter int MAX_BEATS = 16,
  localparam int SUM_W = sum_width(INPUTS, P, MAX_BEATS),
  localparam int CNT_W = cnt_width(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_beats,
  input  logic [P-1:0]     in_data [INPUTS],
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int TREE_W = tree_width(INPUTS, P);

  if (!is_pow2(INPUTS)) begin : g_bad_inputs
    $fatal(1, "INPUTS must be a power of 2");
  end
  if (!is_pow2(MAX_BEATS)) begin : g_bad_max_beats
    $fatal(1, "MAX_BEATS must be a power of 2");
  end

`ifdef TREE_REDUCE_PIPE_EN
  // the last beat still sits in the pipe register, so drain it before DONE
  localparam state_e LAST_ST = DRAIN;
`else
  localparam state_e LAST_ST = DONE;
`endif

  logic [TREE_W-1:0] tree_sum;
  logic [SUM_W-1:0]  tree_ext;
  logic [CNT_W-1:0]  cfg_dec;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hs;

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;

`ifdef TREE_REDUCE_PIPE_EN
  logic [SUM_W-1:0]  pipe_sum_q, pipe_sum_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic              pipe_first_q, pipe_first_d;
`endif

  binary_tree_adder_unsigned #(
    .INPUTS_AMOUNT(INPUTS),
    .P            (P)
  ) u_tree (
    .in_data(in_data),
    .sum    (tree_sum)
  );

  assign tree_ext = SUM_W'(tree_sum);
  assign cfg_dec  = CNT_W'(decode_beats(int'(cfg_beats), MAX_BEATS));
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign hs       = in_valid && in_ready;

  // reduction FSM: beat counting, target latch and handshake signalling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d   = CNT_W'(1);
          tgt_d   = cfg_dec;
          state_d = (cfg_dec == CNT_W'(1)) ? LAST_ST : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == tgt_q) begin
            state_d = LAST_ST;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef TREE_REDUCE_PIPE_EN
  // capture tree sum on handshake; fold the previous cycle's captured sum into acc
  always_comb begin
    pipe_sum_d   = hs ? tree_ext : pipe_sum_q;
    pipe_vld_d   = hs;
    pipe_first_d = hs ? (state_q == IDLE) : pipe_first_q;
    acc_d        = acc_q;
    if (pipe_vld_q) begin
      acc_d = pipe_first_q ? pipe_sum_q : (acc_q + pipe_sum_q);
    end
  end
`else
  // first beat loads the accumulator, later beats add into it
  always_comb begin
    acc_d = acc_q;
    if (hs) begin
      acc_d = (state_q == IDLE) ? tree_ext : (acc_q + tree_ext);
    end
  end
`endif

  // state and datapath registers, reset discards any partial reduction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      tgt_q        <= '0;
`ifdef TREE_REDUCE_PIPE_EN
      pipe_sum_q   <= '0;
      pipe_vld_q   <= 1'b0;
      pipe_first_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
`ifdef TREE_REDUCE_PIPE_EN
      pipe_sum_q   <= pipe_sum_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_first_q <= pipe_first_d;
`endif
    end
  end

  assign out_sum  = acc_q;
  assign busy     = (state_q != IDLE);
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_tree_reduce_sequencer.sv
// tb/tb_tree_reduce_sequencer.sv - randomized self-checking bench for tree_reduce_sequencer
module tb_tree_reduce_sequencer;

`ifdef TREE_REDUCE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [7:0] beat_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cfg_beats;
  beat_t       in_data;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] out_sum;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [4:0]  beat_cnt;

  int errors = 0;
  int checks = 0;

  tree_reduce_sequencer #(.INPUTS(8), .P(8), .MAX_BEATS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_beats(cfg_beats),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t fill(input int v);
    beat_t b;
    for (int i = 0; i < 8; i++) b[i] = v[7:0];
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  function automatic int beat_total(input beat_t b);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(b[i]);
    return s;
  endfunction

  function automatic int model_beats(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > 16) return 16;
    return cfg;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input beat_t b, input int cfg, input int gap);
    int n = 0;
    in_data   = b;
    cfg_beats = cfg[4:0];
    in_valid  = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    checks++;
    tick();
    in_valid = 1'b0;
    in_data  = rand_beat();
    repeat (gap) tick();
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_sum !== 15'd0) begin errors++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (beat_cnt !== 5'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
  endtask

  task automatic test_single_beat();
    int cyc;
    send_beat(fill(255), 1, 0);
    wait_out(cyc);
    checks += 3;
    if (cyc != LAT || out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %0d cycles valid=%b want %0d", cyc, out_valid, LAT); end
    if (out_sum !== 15'd2040) begin errors++; $display("FAIL single_sum: got %0d want 2040", out_sum); end
    if (beat_cnt !== 5'd1) begin errors++; $display("FAIL single_beat_cnt: got %0d want 1", beat_cnt); end
    consume();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_idle: busy=%b in_ready=%b want 0/1", busy, in_ready); end
  endtask

  task automatic test_full_length();
    int cyc;
    for (int k = 0; k < 16; k++) send_beat(fill(255), 16, 0);
    wait_out(cyc);
    checks += 3;
    if (cyc != LAT) begin errors++; $display("FAIL full_latency: got %0d want %0d", cyc, LAT); end
    if (out_sum !== 15'd32640) begin errors++; $display("FAIL full_sum: got %0d want 32640", out_sum); end
    if (beat_cnt !== 5'd16) begin errors++; $display("FAIL full_beat_cnt: got %0d want 16", beat_cnt); end
    consume();
  endtask

  task automatic test_gapped();
    int cyc;
    int exp = 0;
    for (int k = 0; k < 3; k++) begin
      send_beat(fill(k + 1), 3, 0);
      exp += 8 * (k + 1);
      if (k < 2) begin
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (beat_cnt !== 5'(k + 1)) begin errors++; $display("FAIL gap_beat_cnt: got %0d want %0d", beat_cnt, k + 1); end
          tick();
        end
      end
    end
    wait_out(cyc);
    checks += 2;
    if (cyc != LAT) begin errors++; $display("FAIL gap_latency: got %0d want %0d", cyc, LAT); end
    if (out_sum !== 15'(exp)) begin errors++; $display("FAIL gap_sum: got %0d want %0d", out_sum, exp); end
    consume();
  endtask

  task automatic test_backpressure();
    int cyc;
    send_beat(fill(1), 2, 0);
    send_beat(fill(1), 2, 0);
    wait_out(cyc);
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 15'd16) begin
        errors++;
        $display("FAIL bp_hold: valid=%b in_ready=%b sum=%0d want 1/0/16", out_valid, in_ready, out_sum);
      end
      tick();
    end
    consume();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: busy=%b valid=%b in_ready=%b want 0/0/1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_beat(fill(3), 4, 0);
    send_beat(fill(3), 4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    if (beat_cnt !== 5'd0 || out_sum !== 15'd0) begin
      errors++;
      $display("FAIL midrst_clear: beat_cnt=%0d sum=%0d want 0/0", beat_cnt, out_sum);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_spurious: valid=%b want 0", out_valid); end
    send_beat(fill(1), 1, 0);
    wait_out(cyc);
    checks++;
    if (out_sum !== 15'd8 || cyc != LAT) begin errors++; $display("FAIL midrst_after: sum=%0d cyc=%0d want 8/%0d", out_sum, cyc, LAT); end
    consume();
  endtask

  task automatic test_config_edges();
    int cyc;
    send_beat(fill(2), 0, 0);
    wait_out(cyc);
    checks++;
    if (out_sum !== 15'd16 || beat_cnt !== 5'd1 || cyc != LAT) begin
      errors++;
      $display("FAIL cfg_zero: sum=%0d beat_cnt=%0d cyc=%0d want 16/1/%0d", out_sum, beat_cnt, cyc, LAT);
    end
    consume();
    for (int k = 0; k < 15; k++) send_beat(fill(1), 20, 0);
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_clamp_early: valid=%b busy=%b in_ready=%b want 0/1/1", out_valid, busy, in_ready);
    end
    send_beat(fill(1), 20, 0);
    wait_out(cyc);
    checks++;
    if (out_sum !== 15'd128 || beat_cnt !== 5'd16 || cyc != LAT) begin
      errors++;
      $display("FAIL cfg_clamp: sum=%0d beat_cnt=%0d cyc=%0d want 128/16/%0d", out_sum, beat_cnt, cyc, LAT);
    end
    consume();
    send_beat(fill(1), 3, 0);
    send_beat(fill(1), 2, 0);
    repeat (LAT + 1) tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL cfg_midchange_early: valid=%b want 0", out_valid); end
    send_beat(fill(1), 1, 0);
    wait_out(cyc);
    checks++;
    if (out_sum !== 15'd24 || beat_cnt !== 5'd3) begin
      errors++;
      $display("FAIL cfg_midchange: sum=%0d beat_cnt=%0d want 24/3", out_sum, beat_cnt);
    end
    consume();
  endtask

  task automatic test_random();
    int cyc, cfg, nb, exp, gap, stall;
    beat_t b;
    for (int r = 0; r < 10; r++) begin
      cfg = $urandom_range(0, 20);
      nb  = model_beats(cfg);
      exp = 0;
      for (int k = 0; k < nb; k++) begin
        b    = rand_beat();
        exp += beat_total(b);
        gap  = (k == nb - 1) ? 0 : $urandom_range(0, 2);
        send_beat(b, (k == 0) ? cfg : $urandom_range(0, 31), gap);
      end
      wait_out(cyc);
      checks += 3;
      if (cyc != LAT) begin errors++; $display("FAIL rand_latency: run %0d got %0d want %0d", r, cyc, LAT); end
      if (out_sum !== 15'(exp)) begin errors++; $display("FAIL rand_sum: run %0d got %0d want %0d", r, out_sum, exp); end
      if (beat_cnt !== 5'(nb)) begin errors++; $display("FAIL rand_beat_cnt: run %0d got %0d want %0d", r, beat_cnt, nb); end
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      checks++;
      if (out_sum !== 15'(exp) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_hold: run %0d sum=%0d valid=%b want %0d/1", r, out_sum, out_valid, exp);
      end
      consume();
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_beats = '0;
    in_data   = fill(0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_full_length();
    test_gapped();
    test_backpressure();
    test_reset_mid();
    test_config_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
